data_memory: RTL and testbench

- Word-organised data memory for the single-cycle/pipelined MIPS datapath; sits in the MEM stage and is driven by the ALU result (Address) and the rt register value (WriteData).
- Synchronous write, combinational read gated by MemRead.
- After reset it runs a hardware clear sequence that zeroes every word, then accepts traffic.

---
 rtl/data_memory.sv | 102 ++++++++++
 tb/tb_data_memory.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-indexed MIPS data memory with post-reset hardware clear sweep
// Optional macro DATAMEM_REG_READ_EN registers ReadData (1-cycle latency, read-before-write).
module data_memory #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        AddrErr
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt;
    logic            in_range;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;
    logic [31:0]     rd_comb;
    logic [31:0]     mem [DEPTH];

    assign in_range = (Address[31:AW] == '0);
    assign AddrErr  = (MemRead | MemWrite) & ~in_range;
    assign Ready    = (state == READY);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // The clear sweep owns the write port; user writes only once READY.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt;
        mem_wdata  = '0;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                mem_waddr = Address[AW-1:0];
                mem_wdata = WriteData;
                // An X/Z enable takes the false branch, so it never writes.
                if (MemWrite && in_range) begin
                    mem_we = 1'b1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Memory has no reset; Rst_n only blocks writes so contents survive a held reset.
    always_ff @(posedge Clk) begin
        if (Rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_comb = (state == READY && MemRead && in_range) ? mem[Address[AW-1:0]] : '0;

`ifdef DATAMEM_REG_READ_EN
    logic [31:0] rd_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_comb;
        end
    end

    assign ReadData = rd_q;
`else
    assign ReadData = rd_comb;
`endif

    mem_write_known: assert property (@(posedge Clk) disable iff (!Rst_n) !$isunknown(MemWrite))
        else $warning("data_memory: MemWrite is X/Z, write suppressed");

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed vector bench for data_memory
module tb_data_memory;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Ready;
    logic        AddrErr;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        int          cycles;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    data_memory #(.DEPTH(1024), .AW(10)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .AddrErr   (AddrErr)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void add(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic we, input logic re, input int cycles,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.we = we; v.re = re;
        v.cycles = cycles; v.exp_rd = exp_rd; v.exp_err = exp_err;
        vq.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge Clk);
        Address = v.addr; WriteData = v.wdata; MemWrite = v.we; MemRead = v.re;
        #5;
        chk($sformatf("vec%0d addrerr", idx), {31'd0, AddrErr}, {31'd0, v.exp_err});
`ifndef DATAMEM_REG_READ_EN
        chk($sformatf("vec%0d readdata", idx), ReadData, v.exp_rd);
`endif
        repeat (v.cycles) @(posedge Clk);
        #1;
`ifdef DATAMEM_REG_READ_EN
        chk($sformatf("vec%0d readdata", idx), ReadData, v.exp_rd);
`endif
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 1100 && Ready !== 1'b1; i++) begin
            @(posedge Clk);
            #1;
        end
        chk(name, {31'd0, Ready}, 32'd1);
    endtask

    task automatic read_word(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge Clk);
        Address = addr; MemRead = 1'b1; MemWrite = 1'b0;
        @(posedge Clk);
        #1;
        chk(name, ReadData, exp);
    endtask

    initial begin
        Rst_n = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;

        add(32'd0,    32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b0);
        add(32'd500,  32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b0);
        add(32'd1023, 32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b0);
        add(32'd5,    32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b0);
        add(32'd10,   32'd653,  1'b1, 1'b0, 5, 32'd0,    1'b0);
        add(32'd11,   32'd221,  1'b1, 1'b0, 5, 32'd0,    1'b0);
        add(32'd12,   32'd421,  1'b1, 1'b0, 5, 32'd0,    1'b0);
        add(32'd13,   32'd1343, 1'b1, 1'b0, 5, 32'd0,    1'b0);
        add(32'd14,   32'd5531, 1'b1, 1'b0, 5, 32'd0,    1'b0);
        add(32'd781,  32'd741,  1'b1, 1'b0, 5, 32'd0,    1'b0);
        add(32'd10,   32'd0,    1'b0, 1'b1, 1, 32'd653,  1'b0);
        add(32'd11,   32'd0,    1'b0, 1'b1, 1, 32'd221,  1'b0);
        add(32'd12,   32'd0,    1'b0, 1'b1, 1, 32'd421,  1'b0);
        add(32'd13,   32'd0,    1'b0, 1'b1, 1, 32'd1343, 1'b0);
        add(32'd14,   32'd0,    1'b0, 1'b1, 1, 32'd5531, 1'b0);
        add(32'd781,  32'd0,    1'b0, 1'b1, 1, 32'd741,  1'b0);
        add(32'd781,  32'd0,    1'b0, 1'b0, 1, 32'd0,    1'b0);
        add(32'd10,   32'd0,    1'b0, 1'b0, 1, 32'd0,    1'b0);
        add(32'h400,  32'd77,   1'b1, 1'b0, 1, 32'd0,    1'b1);
        add(32'd0,    32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b0);
        add(32'h400,  32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b1);
        add(32'h8000000A, 32'd0, 1'b0, 1'b1, 1, 32'd0,   1'b1);
        add(32'd1023, 32'd0,    1'b0, 1'b1, 1, 32'd0,    1'b0);

        // Reset held for 3 cycles, then count the clear sweep edge by edge.
        repeat (3) @(posedge Clk);
        #1;
        chk("reset readdata", ReadData, 32'd0);
        chk("reset ready", {31'd0, Ready}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 1; i <= 1023; i++) begin
            @(posedge Clk);
            #1;
            if (i == 500) begin
                Address = 32'd5; WriteData = 32'd123; MemWrite = 1'b1; MemRead = 1'b1;
            end
            if (i == 505) begin
                chk("clear readdata gated", ReadData, 32'd0);
                chk("clear addrerr", {31'd0, AddrErr}, 32'd0);
            end
            if (i == 510) begin
                MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
            end
        end
        chk("ready at 1023 edges", {31'd0, Ready}, 32'd0);
        @(posedge Clk);
        #1;
        chk("ready at 1024 edges", {31'd0, Ready}, 32'd1);

        foreach (vq[i]) apply(vq[i], i);

        // Same-cycle read and write on word 12.
        @(negedge Clk);
        Address = 32'd12; WriteData = 32'd999; MemWrite = 1'b1; MemRead = 1'b1;
        #5;
`ifndef DATAMEM_REG_READ_EN
        chk("rw same addr before edge", ReadData, 32'd421);
`endif
        @(posedge Clk);
        #1;
`ifdef DATAMEM_REG_READ_EN
        chk("rw same addr registered old", ReadData, 32'd421);
`else
        chk("rw same addr after edge", ReadData, 32'd999);
`endif
        MemWrite = 1'b0;
        @(posedge Clk);
        #1;
        chk("rw same addr new value", ReadData, 32'd999);

        // Asynchronous reset between edges during operation.
        read_word(32'd781, 32'd741, "pre-reset word 781");
        #4;
        Rst_n = 1'b0;
        #1;
        chk("async reset readdata", ReadData, 32'd0);
        chk("async reset ready", {31'd0, Ready}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        MemRead = 1'b0;
        wait_ready("ready after re-clear");
        read_word(32'd781, 32'd0, "re-cleared word 781");
        read_word(32'd10, 32'd0, "re-cleared word 10");

        MemRead = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
